// File: rtl/data_mem_pkg.sv
// Shared operation, size and dump-state codes for the MEM-stage data memory bank.
package data_mem_pkg;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_ST   = 2'b01;
  localparam logic [1:0] OP_LD   = 2'b10;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, SEND, DONE} dump_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sub-word stores and loads: byte enables, replicated
// store data, extended load data and alignment check.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rword[{addr_lo, 3'b000} +: 8];
  assign half_v = rword[{addr_lo[1], 4'b0000} +: 16];

  // Store data is replicated across lanes; the byte enables pick the live lane.
  always_comb begin
    be         = 4'b1111;
    wdata_sh   = wdata;
    rdata_ext  = rword;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = unsigned_ld ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      SZ_H: begin
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh   = {2{wdata[15:0]}};
        rdata_ext  = unsigned_ld ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/data_mem_bank.sv
// MIPS MEM-stage data memory: sub-word loads/stores with range/alignment checks,
// random-access debug read and a valid/ready full-memory dump engine.
module data_mem_bank
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               read_write,
  input  logic [1:0]               size,
  input  logic                     unsigned_ld,
  input  logic [31:0]              inAddress,
  input  logic [DATA_W-1:0]        inWriteData,
  input  logic                     stop_debug,
  input  logic                     Debug_on,
  input  logic [$clog2(DEPTH)-1:0] Debug_read_mem,
  input  logic                     dump_start,
  input  logic                     dump_ready,
  output logic [DATA_W-1:0]        outData,
  output logic [DATA_W-1:0]        outMemDebug,
  output logic [1:0]               mem_err,
  output logic                     dump_valid,
  output logic [$clog2(DEPTH)-1:0] dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_K = AW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] out_data_q, dbg_q, ddata_q, ddata_d;
  logic [1:0]        mem_err_q;
  logic [AW-1:0]     k_q, k_d, idx;
  dump_state_e       state_q, state_d;

  logic              acc, oor, mis, err;
  logic [3:0]        be;
  logic [31:0]       wsh, rext;

  assign acc = !Debug_on && !stop_debug && (read_write == OP_ST || read_write == OP_LD);
  assign idx = inAddress[AW+1:2];
  assign oor = (inAddress >> (AW + 2)) != 32'd0;
  assign err = mis || oor;

  mem_lane_align u_align (
    .size        (size),
    .addr_lo     (inAddress[1:0]),
    .unsigned_ld (unsigned_ld),
    .wdata       (inWriteData),
    .rword       (mem_q[idx]),
    .be          (be),
    .wdata_sh    (wsh),
    .rdata_ext   (rext),
    .misaligned  (mis)
  );

  // Access stage: memory write, load result, error flags, debug read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      out_data_q <= '0;
      dbg_q      <= '0;
      mem_err_q  <= '0;
    end else begin
      if (acc && read_write == OP_ST && !err) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mem_q[idx][8*b +: 8] <= wsh[8*b +: 8];
      end
      if (acc) begin
        mem_err_q <= {oor, mis};
        if (err)                     out_data_q <= '0;
        else if (read_write == OP_LD) out_data_q <= rext;
      end else begin
        mem_err_q <= '0;
      end
      if (Debug_on && state_q == IDLE) dbg_q <= mem_q[Debug_read_mem];
    end
  end

  // Dump stage: state, word index and presented word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      ddata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ddata_q <= ddata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ddata_d = ddata_q;
    case (state_q)
      IDLE: begin
        if (dump_start && Debug_on) begin
          state_d = SEND;
          k_d     = '0;
          ddata_d = mem_q[0];
        end
      end
      SEND: begin
        if (!Debug_on) begin
          state_d = IDLE;
        end else if (dump_ready) begin
          if (k_q == LAST_K) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + 1'b1;
            ddata_d = mem_q[k_d];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign outData     = out_data_q;
  assign outMemDebug = dbg_q;
  assign mem_err     = mem_err_q;
  assign dump_valid  = (state_q == SEND);
  assign dump_done   = (state_q == DONE);
  assign dump_addr   = k_q;
  assign dump_data   = ddata_q;

endmodule

// File: tb/tb_data_mem_bank.sv
// Bench for data_mem_bank: byte-addressed reference memory, directed and random
// accesses, debug reads, full dump with backpressure, dump abort and reset.
module tb_data_mem_bank;
  import data_mem_pkg::*;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    read_write, size;
  logic          unsigned_ld;
  logic [31:0]   inAddress, inWriteData;
  logic          stop_debug, Debug_on;
  logic [AW-1:0] Debug_read_mem;
  logic          dump_start, dump_ready;
  logic [31:0]   outData, outMemDebug, dump_data;
  logic [1:0]    mem_err;
  logic          dump_valid, dump_done;
  logic [AW-1:0] dump_addr;

  always #5 clk = ~clk;

  data_mem_bank #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .read_write(read_write), .size(size),
    .unsigned_ld(unsigned_ld), .inAddress(inAddress), .inWriteData(inWriteData),
    .stop_debug(stop_debug), .Debug_on(Debug_on), .Debug_read_mem(Debug_read_mem),
    .dump_start(dump_start), .dump_ready(dump_ready), .outData(outData),
    .outMemDebug(outMemDebug), .mem_err(mem_err), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
  );

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mbytes [4*DEPTH];
  logic [31:0] model_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int k);
    return {mbytes[4*k+3], mbytes[4*k+2], mbytes[4*k+1], mbytes[4*k]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4*DEPTH; i++) mbytes[i] = 8'd0;
    model_out = '0;
  endtask

  // One pipeline access; the reference works on a little-endian byte array.
  task automatic access(input logic [1:0] rw, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic stp, input logic dbg);
    logic        acc, mis, oor;
    logic [31:0] exp_err, v;
    int          nb, ai;
    @(negedge clk);
    read_write = rw; size = sz; unsigned_ld = uns; inAddress = a;
    inWriteData = wd; stop_debug = stp; Debug_on = dbg;
    nb  = (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
    acc = !dbg && !stp && (rw == OP_ST || rw == OP_LD);
    mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
    oor = a >= 32'(4*DEPTH);
    ai  = int'(a[6:0]);
    exp_err = '0;
    if (acc) begin
      exp_err = {30'd0, oor, mis};
      if (mis || oor) begin
        model_out = '0;
      end else if (rw == OP_ST) begin
        for (int i = 0; i < nb; i++) mbytes[ai+i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(mbytes[ai+i]) << (8*i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
        model_out = v;
      end
    end
    @(posedge clk); #1;
    chk("outData", outData, model_out);
    chk("mem_err", {30'd0, mem_err}, exp_err);
  endtask

  task automatic dbg_read(input int k);
    @(negedge clk);
    Debug_on = 1'b1; read_write = OP_IDLE; Debug_read_mem = AW'(k);
    @(posedge clk); #1;
    chk("outMemDebug", outMemDebug, mword(k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int   exp_k, xfers, done_cnt;
    logic rdy;
    logic [31:0] a;

    rst = 1'b1; read_write = OP_IDLE; size = SZ_W; unsigned_ld = 1'b0;
    inAddress = '0; inWriteData = '0; stop_debug = 1'b0; Debug_on = 1'b0;
    Debug_read_mem = '0; dump_start = 1'b0; dump_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_outData", outData, 32'd0);
    chk("rst_outMemDebug", outMemDebug, 32'd0);
    chk("rst_mem_err", {30'd0, mem_err}, 32'd0);
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_dump_done", 32'(dump_done), 32'd0);
    chk("rst_dump_addr", 32'(dump_addr), 32'd0);
    chk("rst_dump_data", dump_data, 32'd0);

    for (int i = 0; i < DEPTH; i++) access(OP_ST, SZ_W, 1'b0, 32'(4*i), $urandom(), 1'b0, 1'b0);

    // Word store/load, byte store with signed/unsigned loads.
    access(OP_ST, SZ_W, 1'b0, 32'h10, 32'h11223344, 1'b0, 1'b0);
    access(OP_LD, SZ_W, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    access(OP_ST, SZ_B, 1'b0, 32'h11, 32'hABCDEF80, 1'b0, 1'b0);
    access(OP_LD, SZ_B, 1'b0, 32'h11, 32'h0, 1'b0, 1'b0);
    access(OP_LD, SZ_B, 1'b1, 32'h11, 32'h0, 1'b0, 1'b0);
    access(OP_LD, SZ_W, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    access(OP_ST, SZ_H, 1'b0, 32'h16, 32'h0000F00D, 1'b0, 1'b0);
    access(OP_LD, SZ_H, 1'b0, 32'h16, 32'h0, 1'b0, 1'b0);
    access(OP_LD, SZ_H, 1'b1, 32'h16, 32'h0, 1'b0, 1'b0);

    // Error cases, then stalled and debug-mode accesses.
    access(OP_LD, SZ_H, 1'b0, 32'h3, 32'h0, 1'b0, 1'b0);
    access(OP_ST, SZ_W, 1'b0, 32'h200, 32'hCAFEBABE, 1'b0, 1'b0);
    access(OP_LD, SZ_W, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    access(OP_ST, SZ_W, 1'b0, 32'h22, 32'h12345678, 1'b0, 1'b0);
    access(OP_ST, SZ_W, 1'b0, 32'h20, 32'hDEADBEEF, 1'b1, 1'b0);
    access(OP_ST, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
    access(OP_LD, SZ_W, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0);
    access(OP_LD, SZ_W, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
    access(OP_LD, SZ_W, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    access(OP_LD, SZ_B, 1'b0, 32'h13, 32'h0, 1'b0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) a = 32'h80 + 32'($urandom_range(0, 4000));
      else                            a = 32'($urandom_range(0, 4*DEPTH - 1));
      access(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    for (int n = 0; n < 8; n++) dbg_read(int'($urandom_range(0, DEPTH - 1)));

    // Full dump with ready toggling every cycle.
    @(negedge clk);
    Debug_on = 1'b1; read_write = OP_IDLE; dump_ready = 1'b0; dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0;
    exp_k = 0; xfers = 0; done_cnt = 0; rdy = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (dump_done) begin
        done_cnt++;
        break;
      end
      chk("dump_valid", 32'(dump_valid), 32'd1);
      chk("dump_addr", 32'(dump_addr), 32'(exp_k % DEPTH));
      chk("dump_data", dump_data, mword(exp_k % DEPTH));
      rdy = ~rdy; dump_ready = rdy;
      if (rdy) begin
        xfers++;
        exp_k++;
      end
      @(negedge clk);
    end
    dump_ready = 1'b0;
    chk("dump_xfers", 32'(xfers), 32'(DEPTH));
    chk("dump_done_seen", 32'(done_cnt), 32'd1);
    @(negedge clk);
    chk("dump_done_once", 32'(dump_done), 32'd0);
    chk("dump_idle_valid", 32'(dump_valid), 32'd0);

    // Abort by dropping Debug_on at k=5.
    dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (dump_valid && dump_addr == AW'(5)) break;
      dump_ready = 1'b1;
      @(negedge clk);
    end
    chk("abort_k", 32'(dump_addr), 32'd5);
    chk("abort_data", dump_data, mword(5));
    dump_ready = 1'b0; Debug_on = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(dump_valid), 32'd0);
    chk("abort_done", 32'(dump_done), 32'd0);
    @(negedge clk);
    chk("abort_done_late", 32'(dump_done), 32'd0);

    // Reset in the middle of a dump.
    Debug_on = 1'b1; dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0; dump_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; dump_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_clear();
    chk("rstdump_valid", 32'(dump_valid), 32'd0);
    chk("rstdump_addr", 32'(dump_addr), 32'd0);
    chk("rstdump_data", dump_data, 32'd0);
    chk("rstdump_outData", outData, 32'd0);
    for (int k = 0; k < DEPTH; k++) dbg_read(k);
    access(OP_LD, SZ_W, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    access(OP_LD, SZ_B, 1'b0, 32'h7F, 32'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
